// File: rtl/rx_ber_checker.sv
// Receive-side BER checker: decimates the oversampled filter output, slices the sign,
// searches for the reference delay that best matches, then counts bits and errors.
module rx_ber_checker #(
    parameter int NBIT_IN   = 12,
    parameter int USAMPLE   = 4,
    parameter int MAX_DELAY = 32,
    parameter int WINDOW    = 511,
    parameter int LOSS_THR  = 128,
    parameter int CNT_BITS  = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         clear,
    input  logic [$clog2(USAMPLE)-1:0]   phase_sel,
    input  logic signed [NBIT_IN-1:0]    sample_in,
    input  logic                         ref_bit,
    output logic                         rx_bit,
    output logic                         bit_valid,
    output logic                         locked,
    output logic [$clog2(MAX_DELAY)-1:0] delay_out,
    output logic [CNT_BITS-1:0]          bit_count,
    output logic [CNT_BITS-1:0]          err_count
);

    localparam int PH_W  = $clog2(USAMPLE);
    localparam int DL_W  = $clog2(MAX_DELAY);
    localparam int WIN_W = $clog2(WINDOW + 1);
    localparam logic signed [NBIT_IN-1:0] ZERO = '0;

    typedef enum logic [1:0] {IDLE, SEARCH, LOCKED} state_t;

    state_t           state;
    logic [PH_W-1:0]  phase;
    logic             en_d;
    logic [MAX_DELAY-1:0] line;
    logic [WIN_W-1:0] win_cnt;
    logic [WIN_W-1:0] win_err;
    logic [WIN_W-1:0] min_err;
    logic [DL_W-1:0]  best;

    logic [PH_W-1:0]  cur_phase;
    logic             vld_p0;
    logic             dec_p0;
    logic             err_p0;
    logic             win_last;
    logic [WIN_W-1:0] win_err_nx;
    logic             better;

    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v,
                                                   input logic inc);
        return (inc && (v != '1)) ? v + 1'b1 : v;
    endfunction

    // Phase restarts at 0 on the first enabled cycle after a gap in the stream.
    always_comb begin
        cur_phase  = en_d ? phase : '0;
        vld_p0     = enable && (cur_phase == phase_sel);
        dec_p0     = (sample_in < ZERO);
        err_p0     = dec_p0 ^ line[delay_out];
        win_last   = (win_cnt == WIN_W'(WINDOW - 1));
        win_err_nx = win_err + {{(WIN_W-1){1'b0}}, err_p0};
        better     = (win_err_nx < min_err);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            phase     <= '0;
            en_d      <= 1'b0;
            line      <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
            min_err   <= '1;
            best      <= '0;
            rx_bit    <= 1'b0;
            bit_valid <= 1'b0;
            locked    <= 1'b0;
            delay_out <= '0;
            bit_count <= '0;
            err_count <= '0;
        end else begin
            en_d      <= enable;
            bit_valid <= vld_p0;
            if (vld_p0)
                rx_bit <= dec_p0;
            if (enable) begin
                phase <= cur_phase + 1'b1;
                if (cur_phase == PH_W'(USAMPLE - 1))
                    line <= {line[MAX_DELAY-2:0], ref_bit};
            end

            if (clear) begin
                bit_count <= '0;
                err_count <= '0;
            end

            if (!enable) begin
                state  <= IDLE;
                locked <= 1'b0;
            end else if (clear || state == IDLE) begin
                state     <= SEARCH;
                locked    <= 1'b0;
                delay_out <= '0;
                win_cnt   <= '0;
                win_err   <= '0;
                min_err   <= '1;
                best      <= '0;
            end else if (vld_p0) begin
                case (state)
                    SEARCH: begin
                        if (win_last) begin
                            win_cnt <= '0;
                            win_err <= '0;
                            if (better) begin
                                min_err <= win_err_nx;
                                best    <= delay_out;
                            end
                            // Strict compare: ties keep the earlier (smaller) delay.
                            if (delay_out == DL_W'(MAX_DELAY - 1)) begin
                                delay_out <= better ? delay_out : best;
                                locked    <= 1'b1;
                                state     <= LOCKED;
                            end else begin
                                delay_out <= delay_out + 1'b1;
                            end
                        end else begin
                            win_cnt <= win_cnt + 1'b1;
                            win_err <= win_err_nx;
                        end
                    end
                    LOCKED: begin
                        bit_count <= sat_inc(bit_count, 1'b1);
                        err_count <= sat_inc(err_count, err_p0);
                        if (win_last) begin
                            win_cnt <= '0;
                            win_err <= '0;
                            if (win_err_nx > WIN_W'(LOSS_THR)) begin
                                state     <= SEARCH;
                                locked    <= 1'b0;
                                delay_out <= '0;
                                min_err   <= '1;
                                best      <= '0;
                            end
                        end else begin
                            win_cnt <= win_cnt + 1'b1;
                            win_err <= win_err_nx;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rx_ber_checker.sv
// Directed bench for rx_ber_checker with reduced window/delay sizes so each search is short.
module tb_rx_ber_checker;

    localparam int NB   = 12;
    localparam int US   = 4;
    localparam int MD   = 8;
    localparam int WIN  = 31;
    localparam int THR  = 8;
    localparam int CB   = 8;
    localparam int DEXP = 3;

    logic                 clk;
    logic                 reset;
    logic                 enable;
    logic                 clear;
    logic [1:0]           phase_sel;
    logic signed [NB-1:0] sample_in;
    logic                 ref_bit;
    logic                 rx_bit;
    logic                 bit_valid;
    logic                 locked;
    logic [2:0]           delay_out;
    logic [CB-1:0]        bit_count;
    logic [CB-1:0]        err_count;

    rx_ber_checker #(
        .NBIT_IN(NB), .USAMPLE(US), .MAX_DELAY(MD),
        .WINDOW(WIN), .LOSS_THR(THR), .CNT_BITS(CB)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear),
        .phase_sel(phase_sel), .sample_in(sample_in), .ref_bit(ref_bit),
        .rx_bit(rx_bit), .bit_valid(bit_valid), .locked(locked),
        .delay_out(delay_out), .bit_count(bit_count), .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    logic bits [0:510];
    int   k;
    int   inj_per;
    logic invert;
    logic tie;
    logic chk_rx;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Sample at symbol kk carries the reference bit DEXP+1 symbols older.
    function automatic logic exp_bit(input int kk);
        int i;
        i = kk - 1 - DEXP;
        return (i >= 0) ? bits[i % 511] : 1'b0;
    endfunction

    task automatic drive_cycle(input int p);
        logic e;
        logic neg;
        e = exp_bit(k) ^ invert ^ ((inj_per != 0) && (k % inj_per == 0));
        ref_bit = tie ? 1'b0 : bits[k % 511];
        neg = (p == 0) ? e : ~e;
        if (tie)
            sample_in = (p == 0) ? 12'sd0 : -12'sd5;
        else
            sample_in = neg ? -12'sd100 : 12'sd100;
        @(posedge clk); #1;
        if (chk_rx && p == 0) begin
            check_eq("bit_valid", bit_valid, 1);
            check_eq("rx_bit", rx_bit, tie ? 1'b0 : e);
        end
        if (chk_rx && p == 1)
            check_eq("valid_pulse", bit_valid, 0);
    endtask

    task automatic run_sym(input int n);
        for (int s = 0; s < n; s++) begin
            for (int p = 0; p < US; p++)
                drive_cycle(p);
            k++;
        end
    endtask

    task automatic wait_lock(input string tag, input int budget);
        int n;
        n = 0;
        while (!locked && n < budget) begin
            run_sym(1);
            n++;
        end
        check_eq(tag, locked, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] lfsr;
        logic [CB-1:0] b0, e0;
        int n;
        lfsr = 9'h1FF;
        for (int i = 0; i < 511; i++) begin
            bits[i] = lfsr[8] ^ lfsr[4];
            lfsr = {lfsr[7:0], bits[i]};
        end
        reset = 1'b1; enable = 1'b0; clear = 1'b0; phase_sel = 2'd0;
        sample_in = '0; ref_bit = 1'b0;
        k = 0; inj_per = 0; invert = 1'b0; tie = 1'b0; chk_rx = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_locked", locked, 0);
        check_eq("rst_delay", delay_out, 0);
        check_eq("rst_bits", bit_count, 0);
        check_eq("rst_errs", err_count, 0);
        check_eq("rst_valid", bit_valid, 0);
        check_eq("rst_rx", rx_bit, 0);
        reset = 1'b0;

        // Clean loop: lock at delay 3, counting and zero errors
        enable = 1'b1;
        wait_lock("lock1", 400);
        check_eq("delay1", delay_out, DEXP);
        check_eq("errs1", err_count, 0);
        chk_rx = 1'b1;
        run_sym(3);
        chk_rx = 1'b0;
        b0 = bit_count;
        run_sym(40);
        check_eq("bits_delta40", bit_count - b0, 40);
        check_eq("errs_clean", err_count, 0);

        // One injected error every 10 symbols
        inj_per = 10;
        b0 = bit_count; e0 = err_count;
        run_sym(100);
        inj_per = 0;
        check_eq("inj_bits", bit_count - b0, 100);
        check_eq("inj_errs", err_count - e0, 10);
        check_eq("inj_locked", locked, 1);

        // Saturation of bit_count
        run_sym(150);
        check_eq("sat_bits", bit_count, 8'hFF);
        check_eq("sat_errs", err_count, 10);
        run_sym(5);
        check_eq("sat_hold", bit_count, 8'hFF);

        // Drop enable mid-symbol, re-raise restarting the symbol at phase 0
        drive_cycle(0);
        drive_cycle(1);
        enable = 1'b0;
        e0 = err_count;
        @(posedge clk); #1;
        check_eq("drop_locked", locked, 0);
        repeat (9) @(posedge clk);
        #1;
        check_eq("drop_errs", err_count, e0);
        check_eq("drop_bits", bit_count, 8'hFF);
        check_eq("drop_delay", delay_out, DEXP);
        enable = 1'b1;
        wait_lock("relock", 400);
        check_eq("relock_delay", delay_out, DEXP);
        run_sym(20);
        check_eq("relock_errs", err_count, e0);

        // Clear while locked
        clear = 1'b1;
        drive_cycle(0);
        clear = 1'b0;
        check_eq("clr_bits", bit_count, 0);
        check_eq("clr_errs", err_count, 0);
        check_eq("clr_locked", locked, 0);
        check_eq("clr_delay", delay_out, 0);
        for (int p = 1; p < US; p++)
            drive_cycle(p);
        k++;
        wait_lock("lock_clr", 400);
        check_eq("clr_relock_delay", delay_out, DEXP);

        // Inverted stream must exceed the loss threshold
        invert = 1'b1;
        n = 0;
        while (locked && n < 2 * WIN + 4) begin
            run_sym(1);
            n++;
        end
        check_eq("loss_locked", locked, 0);
        check_eq("loss_delay", delay_out, 0);
        e0 = err_count;
        check_eq("loss_errs_gt_thr", (e0 > THR), 1);
        run_sym(10);
        check_eq("loss_errs_hold", err_count, e0);
        invert = 1'b0;

        // Asynchronous reset in the middle of a search
        n = 0;
        while (delay_out != 3'd5 && n < 200) begin
            run_sym(1);
            n++;
        end
        check_eq("search_d5", delay_out, 5);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("arst_delay", delay_out, 0);
        check_eq("arst_bits", bit_count, 0);
        check_eq("arst_errs", err_count, 0);
        check_eq("arst_locked", locked, 0);
        check_eq("arst_valid", bit_valid, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // All candidates tie: smallest delay wins; zero sample slices to 0
        tie = 1'b1;
        k = 0;
        wait_lock("lock_tie", 400);
        check_eq("tie_delay", delay_out, 0);
        chk_rx = 1'b1;
        run_sym(20);
        chk_rx = 1'b0;
        check_eq("tie_errs", err_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
